// File: rtl/mux_nto1_rr.sv
// -----------------------------------------------------------------------------
// mux_nto1_rr
//
// N-channel, W-bit channel-merging multiplexer with one registered output stage.
// Each input and the output carry a valid/ready handshake. The source channel
// comes either from an external select (mode=0) or from a round-robin scan over
// the channels that are currently requesting (mode=1).
//
// Parameters
//   WIDTH     data bits per channel (>=1)
//   CHANNELS  number of input channels (>=2)
//   SEL_W     derived channel-index width, max(1, clog2(CHANNELS))
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   packed channel data, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel ready (combinational)
//   mode       in   0 = fixed select through sel, 1 = round-robin
//   sel        in   channel index used when mode=0
//   out_data   out  registered data of the selected channel
//   out_valid  out  registered output valid
//   out_ready  in   downstream ready
//   out_chan   out  index of the channel held in the output register
// -----------------------------------------------------------------------------
module mux_nto1_rr #(
    parameter int  WIDTH    = 2,
    parameter int  CHANNELS = 2,
    localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    // Isolate the lowest set bit of a request vector (v & -v).
    function automatic logic [CHANNELS-1:0] lowest_onehot(input logic [CHANNELS-1:0] v);
        lowest_onehot = v & (~v + CHANNELS'(1));
    endfunction

    logic                  load_en_s;
    logic [CHANNELS-1:0]   fix_grant_s;
    logic [CHANNELS-1:0]   hi_mask_s;
    logic [CHANNELS-1:0]   hi_req_s;
    logic [CHANNELS-1:0]   rr_grant_s;
    logic [CHANNELS-1:0]   grant_s;
    logic [SEL_W-1:0]      grant_idx_s;
    logic [WIDTH-1:0]      grant_data_s;
    logic                  in_xfer_s;

    logic [WIDTH-1:0]      out_data_r;
    logic                  out_valid_r;
    logic [SEL_W-1:0]      out_chan_r;
    logic [SEL_W-1:0]      last_r;

    // The register can accept a new word when it is empty or being drained.
    assign load_en_s = ~out_valid_r | out_ready;

    // Fixed-select grant; a sel value beyond the last channel matches nothing.
    always_comb begin
        fix_grant_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                fix_grant_s[i] = in_valid[i];
            end else begin
                fix_grant_s[i] = 1'b0;
            end
        end
    end

    // Round-robin grant: prefer the lowest requester above the last served
    // channel, otherwise wrap around to the lowest requester overall.
    always_comb begin
        hi_mask_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hi_mask_s[i] = (SEL_W'(i) > last_r);
        end
        hi_req_s = in_valid & hi_mask_s;
        if (|hi_req_s) begin
            rr_grant_s = lowest_onehot(hi_req_s);
        end else begin
            rr_grant_s = lowest_onehot(in_valid);
        end
    end

    // Mode selects which arbiter drives the (at most one-hot) grant.
    always_comb begin
        if (mode) begin
            grant_s = rr_grant_s;
        end else begin
            grant_s = fix_grant_s;
        end
    end

    assign in_ready  = grant_s & {CHANNELS{load_en_s}};
    assign in_xfer_s = |(in_valid & in_ready);

    // Encode the one-hot grant into an index and select that channel's data.
    always_comb begin
        grant_idx_s  = '0;
        grant_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_idx_s  = grant_idx_s  | (SEL_W'(i) & {SEL_W{grant_s[i]}});
            grant_data_s = grant_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

    // Output register and round-robin pointer; a simultaneous drain and load
    // simply reloads, keeping out_valid high with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_chan_r  <= '0;
            last_r      <= SEL_W'(CHANNELS - 1);
        end else if (in_xfer_s) begin
            out_data_r  <= grant_data_s;
            out_valid_r <= 1'b1;
            out_chan_r  <= grant_idx_s;
            last_r      <= grant_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// -----------------------------------------------------------------------------
// tb_mux_nto1_rr
//
// Self-checking bench for mux_nto1_rr. Three instances cover the 2x2-bit,
// 4x8-bit and 3-channel configurations. The 4-channel instance is driven from
// a table of {inputs, expected outputs} rows; the other cases are short
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mux_nto1_rr;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=2, CHANNELS=2
    logic [3:0] a_in_data;
    logic [1:0] a_in_valid;
    logic [1:0] a_in_ready;
    logic       a_mode;
    logic [0:0] a_sel;
    logic [1:0] a_out_data;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [0:0] a_out_chan;

    mux_nto1_rr #(.WIDTH(2), .CHANNELS(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mode(a_mode), .sel(a_sel),
        .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_chan(a_out_chan)
    );

    // Instance B: WIDTH=8, CHANNELS=4
    logic [31:0] b_in_data;
    logic [3:0]  b_in_valid;
    logic [3:0]  b_in_ready;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_out_chan;

    mux_nto1_rr #(.WIDTH(8), .CHANNELS(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .sel(b_sel),
        .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_chan(b_out_chan)
    );

    // Instance C: WIDTH=4, CHANNELS=3
    logic [11:0] c_in_data;
    logic [2:0]  c_in_valid;
    logic [2:0]  c_in_ready;
    logic        c_mode;
    logic [1:0]  c_sel;
    logic [3:0]  c_out_data;
    logic        c_out_valid;
    logic        c_out_ready;
    logic [1:0]  c_out_chan;

    mux_nto1_rr #(.WIDTH(4), .CHANNELS(3)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .mode(c_mode), .sel(c_sel),
        .out_data(c_out_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_chan(c_out_chan)
    );

    int errors;
    int checks;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_chan;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic r, input logic [3:0] er, input logic ev,
                                input logic [1:0] ec, input logic [7:0] ed);
        vec_t t;
        t.mode = m;  t.sel = s;  t.valid = v;  t.ordy = r;
        t.exp_ready = er;  t.exp_valid = ev;  t.exp_chan = ec;  t.exp_data = ed;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        a_in_data = 4'b1101; a_in_valid = 2'b00; a_mode = 1'b0; a_sel = 1'b0; a_out_ready = 1'b1;
        b_in_data = 32'hA3A2A1A0; b_in_valid = 4'b0000; b_mode = 1'b1; b_sel = 2'd0; b_out_ready = 1'b1;
        c_in_data = 12'h321; c_in_valid = 3'b000; c_mode = 1'b0; c_sel = 2'd0; c_out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        #12;
        check("rst_a_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_a_data",  {30'd0, a_out_data},  32'd0);
        check("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
        check("rst_b_data",  {24'd0, b_out_data},  32'd0);
        check("rst_b_chan",  {30'd0, b_out_chan},  32'd0);
        check("rst_c_valid", {31'd0, c_out_valid}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();

        // Fixed select, 2 channels
        a_in_valid = 2'b11;
        a_sel = 1'b1;
        #1;
        check("t1_ready_sel1", {30'd0, a_in_ready}, 32'h2);
        tick();
        check("t1_data_sel1",  {30'd0, a_out_data}, 32'h3);
        check("t1_chan_sel1",  {31'd0, a_out_chan}, 32'd1);
        check("t1_valid_sel1", {31'd0, a_out_valid}, 32'd1);
        a_sel = 1'b0;
        #1;
        check("t1_ready_sel0", {30'd0, a_in_ready}, 32'h1);
        tick();
        check("t1_data_sel0",  {30'd0, a_out_data}, 32'h1);
        check("t1_chan_sel0",  {31'd0, a_out_chan}, 32'd0);
        a_in_valid = 2'b00;

        // Out-of-range select on 3 channels
        c_in_valid = 3'b111;
        c_sel = 2'd3;
        #1;
        check("t5_ready_sel3", {29'd0, c_in_ready}, 32'h0);
        tick();
        check("t5_valid_sel3a", {31'd0, c_out_valid}, 32'd0);
        tick();
        check("t5_valid_sel3b", {31'd0, c_out_valid}, 32'd0);
        c_sel = 2'd2;
        #1;
        check("t5_ready_sel2", {29'd0, c_in_ready}, 32'h4);
        tick();
        check("t5_valid_sel2", {31'd0, c_out_valid}, 32'd1);
        check("t5_chan_sel2",  {30'd0, c_out_chan},  32'd2);
        check("t5_data_sel2",  {28'd0, c_out_data},  32'h3);
        c_in_valid = 3'b000;

        // Table for the 4-channel instance (pointer starts at 3)
        // round-robin, all requesting
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        // backpressure: output held, no ready
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0));
        // release: continues with next channel in order
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3));
        // sparse wrap with channels 0 and 3
        vq.push_back(mk(1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        vq.push_back(mk(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3));
        vq.push_back(mk(1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        // nothing requesting: drain, data and chan hold
        vq.push_back(mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0));
        // fixed mode moves the pointer; round-robin then continues after it
        vq.push_back(mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2));
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3));
        // selected channel not valid: no grant, output drains
        vq.push_back(mk(1'b0, 2'd1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hA3));

        for (int i = 0; i < vq.size(); i++) begin
            b_mode = vq[i].mode;
            b_sel = vq[i].sel;
            b_in_valid = vq[i].valid;
            b_out_ready = vq[i].ordy;
            #1;
            check($sformatf("vec%0d_ready", i), {28'd0, b_in_ready}, {28'd0, vq[i].exp_ready});
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, b_out_valid}, {31'd0, vq[i].exp_valid});
            check($sformatf("vec%0d_chan", i),  {30'd0, b_out_chan},  {30'd0, vq[i].exp_chan});
            check($sformatf("vec%0d_data", i),  {24'd0, b_out_data},  {24'd0, vq[i].exp_data});
        end

        // Reset mid-operation while stalled with a held word
        b_mode = 1'b1;
        b_in_valid = 4'b1111;
        b_out_ready = 1'b1;
        tick();
        check("t6_pre_chan", {30'd0, b_out_chan}, 32'd0);
        b_out_ready = 1'b0;
        tick();
        check("t6_pre_valid", {31'd0, b_out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, b_out_valid}, 32'd0);
        check("t6_async_data",  {24'd0, b_out_data},  32'd0);
        #2;
        rst_n = 1'b1;
        b_out_ready = 1'b1;
        tick();
        check("t6_post_valid", {31'd0, b_out_valid}, 32'd1);
        check("t6_post_chan",  {30'd0, b_out_chan},  32'd0);
        check("t6_post_data",  {24'd0, b_out_data},  32'hA0);
        tick();
        check("t6_next_chan",  {30'd0, b_out_chan},  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
